// File: rtl/mac_pkg.sv
// Shared constants, FSM state and flag types for the MAC receive stream checker.
package mac_pkg;

  localparam logic [7:0]  LC_IDLE     = 8'h07;
  localparam logic [7:0]  LC_START    = 8'hFB;
  localparam logic [7:0]  LC_TERM     = 8'hFD;
  localparam logic [7:0]  LC_PREAMBLE = 8'h55;
  localparam logic [7:0]  LC_SFD      = 8'hD5;

  localparam logic [47:0] DST_ADDR_DEF = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] SRC_ADDR_DEF = 48'h123456789ABC;

  localparam int          MIN_FRAME_DEF = 64;
  localparam int          MAX_FRAME_DEF = 1518;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  localparam logic [10:0] POS_MAX = 11'd2047;

  typedef enum logic [1:0] {ST_IDLE, ST_FRAME, ST_DROP} state_e;

  typedef struct packed {
    logic preamble;
    logic header;
    logic payload;
    logic fcs;
    logic size;
    logic code;
  } err_flags_t;

  // Byte k of an address as it appears on the wire (k=0 is the MSB, sent first).
  function automatic logic [7:0] addr_byte(input logic [47:0] addr, input logic [2:0] k);
    logic [47:0] sh;
    sh = addr << {k, 3'b000};
    return sh[47:40];
  endfunction

endpackage

// File: rtl/crc32_lanes.sv
// Combinational reflected CRC-32 update over up to LANES bytes, lane 0 first.
module crc32_lanes
  import mac_pkg::*;
#(
  parameter int LANES = 8
) (
  input  logic [31:0]        i_crc,
  input  logic [LANES*8-1:0] i_data,
  input  logic [LANES-1:0]   i_en,
  output logic [31:0]        o_crc
);

  logic [31:0] c;

  always_comb begin
    c = i_crc;
    for (int n = 0; n < LANES; n++) begin
      if (i_en[n]) begin
        c = c ^ {24'h0, i_data[8*n +: 8]};
        for (int b = 0; b < 8; b++)
          c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
      end
    end
    o_crc = c;
  end

endmodule

// File: rtl/mac_stream_checker.sv
// Checks XGMII-style receive frames (preamble, addresses, length, FCS, size,
// control codes) and reports one result strobe per frame with statistics.
module mac_stream_checker
  import mac_pkg::*;
#(
  parameter int          DATA_WIDTH     = 64,
  parameter int          CTRL_WIDTH     = DATA_WIDTH/8,
  parameter logic [7:0]  IDLE_CODE      = LC_IDLE,
  parameter logic [7:0]  START_CODE     = LC_START,
  parameter logic [7:0]  TERM_CODE      = LC_TERM,
  parameter logic [7:0]  PREAMBLE_CODE  = LC_PREAMBLE,
  parameter logic [7:0]  SFD_CODE       = LC_SFD,
  parameter logic [47:0] DST_ADDR_CODE  = DST_ADDR_DEF,
  parameter logic [47:0] SRC_ADDR_CODE  = SRC_ADDR_DEF,
  parameter bit          CHECK_ADDR     = 1'b1,
  parameter int          MIN_FRAME_SIZE = MIN_FRAME_DEF,
  parameter int          MAX_FRAME_SIZE = MAX_FRAME_DEF
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic [CTRL_WIDTH-1:0] i_rx_ctrl,
  input  logic                  i_data_valid,
  output logic                  o_frame_done,
  output logic                  o_preamble_error,
  output logic                  o_header_error,
  output logic                  o_payload_error,
  output logic                  o_fcs_error,
  output logic                  o_size_error,
  output logic                  o_code_error,
  output logic [31:0]           o_frame_count,
  output logic [31:0]           o_error_count
);

  if (CTRL_WIDTH != DATA_WIDTH/8 || (DATA_WIDTH != 64 && DATA_WIDTH != 128) ||
      IDLE_CODE == START_CODE || IDLE_CODE == TERM_CODE) begin : g_bad_cfg
    $error("mac_stream_checker: illegal configuration");
  end

  state_e                state_q, state_d;
  logic [10:0]           pos_q, pos_d;
  logic [31:0]           crc_q, crc_d, crc_seed, crc_next;
  logic [15:0]           lt_q, lt_d;
  logic                  pre_q, pre_d, hdr_q, hdr_d, code_q, code_d, size_q, size_d;
  logic                  done_q, done_d;
  err_flags_t            flags_q, flags_d;
  logic [31:0]           fcnt_q, fcnt_d, ecnt_q, ecnt_d;

  logic [CTRL_WIDTH-1:0] lane_en;
  logic                  restart, busy, term_hit;
  logic [11:0]           base, p, term_pos, pos_nxt;
  logic [7:0]            b;
  logic [16:0]           exp_pay;
  int                    fsize;

  crc32_lanes #(.LANES(CTRL_WIDTH)) u_crc (
    .i_crc  (crc_seed),
    .i_data (i_rx_data),
    .i_en   (lane_en),
    .o_crc  (crc_next)
  );

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    lt_d     = lt_q;
    pre_d    = pre_q;
    hdr_d    = hdr_q;
    code_d   = code_q;
    size_d   = size_q;
    crc_seed = crc_q;
    lane_en  = '0;
    done_d   = 1'b0;
    flags_d  = '0;
    restart  = 1'b0;
    busy     = 1'b0;
    term_hit = 1'b0;
    term_pos = '0;
    base     = {1'b0, pos_q};
    p        = '0;
    b        = '0;
    pos_nxt  = '0;
    exp_pay  = '0;
    fsize    = 0;

    if (i_data_valid) begin
      restart = i_rx_ctrl[0] && (i_rx_data[7:0] == START_CODE);
      // A START in lane 0 mid-frame closes the old frame as a code error.
      if (restart && state_q != ST_IDLE) begin
        done_d  = 1'b1;
        flags_d = '{preamble: pre_q, header: hdr_q, payload: 1'b0, fcs: 1'b0,
                    size: size_q, code: 1'b1};
      end
      if (restart) begin
        state_d  = ST_FRAME;
        pre_d    = 1'b0;
        hdr_d    = 1'b0;
        code_d   = 1'b0;
        size_d   = 1'b0;
        lt_d     = '0;
        crc_seed = CRC_INIT;
        base     = '0;
      end
      busy = restart || (state_q != ST_IDLE);

      for (int n = 0; n < CTRL_WIDTH; n++) begin
        p = base + 12'(n);
        b = i_rx_data[8*n +: 8];
        if (busy && !term_hit && !(restart && n == 0)) begin
          if (i_rx_ctrl[n] && b == TERM_CODE) begin
            term_hit = 1'b1;
            term_pos = p;
          end else if (i_rx_ctrl[n]) begin
            code_d  = 1'b1;
            if (p <= 12'd7) pre_d = 1'b1;
            state_d = ST_DROP;
          end else begin
            lane_en[n] = (p >= 12'd8);
            if (state_d == ST_FRAME) begin
              if (p >= 12'd1 && p <= 12'd6 && b != PREAMBLE_CODE) pre_d = 1'b1;
              if (p == 12'd7 && b != SFD_CODE) pre_d = 1'b1;
              if (CHECK_ADDR && p >= 12'd8 && p <= 12'd13 &&
                  b != addr_byte(DST_ADDR_CODE, 3'(p - 12'd8)))  hdr_d = 1'b1;
              if (CHECK_ADDR && p >= 12'd14 && p <= 12'd19 &&
                  b != addr_byte(SRC_ADDR_CODE, 3'(p - 12'd14))) hdr_d = 1'b1;
              if (p == 12'd20) lt_d[15:8] = b;
              if (p == 12'd21) lt_d[7:0]  = b;
            end
          end
        end
      end

      if (busy && !term_hit) begin
        pos_nxt = base + 12'(CTRL_WIDTH);
        if (pos_nxt >= {1'b0, POS_MAX}) begin
          pos_d = POS_MAX;
          if (state_d == ST_FRAME) begin
            size_d  = 1'b1;
            state_d = ST_DROP;
          end
        end else begin
          pos_d = pos_nxt[10:0];
        end
      end

      if (term_hit) begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
        flags_d = '{preamble: pre_d, header: hdr_d, payload: 1'b0, fcs: 1'b0,
                    size: size_d, code: code_d};
        // A frame cut off inside the preamble has no FCS or payload to judge.
        if (term_pos < 12'd8) begin
          flags_d.preamble = 1'b1;
          flags_d.size     = 1'b1;
        end else begin
          fsize = int'(term_pos) - 8;
          if (fsize < MIN_FRAME_SIZE || fsize > MAX_FRAME_SIZE) flags_d.size = 1'b1;
          flags_d.fcs = (crc_next != CRC_RESIDUE);
          exp_pay = (lt_d >= 16'd46) ? {1'b0, lt_d} : 17'd46;
          if (lt_d <= 16'd1500)
            flags_d.payload = ({5'b0, term_pos} != exp_pay + 17'd26);
          else if (lt_d <= 16'd1535)
            flags_d.payload = 1'b1;
        end
      end
    end

    crc_d  = crc_next;
    fcnt_d = (done_d && fcnt_q != 32'hFFFFFFFF) ? fcnt_q + 32'd1 : fcnt_q;
    ecnt_d = ((|flags_d) && ecnt_q != 32'hFFFFFFFF) ? ecnt_q + 32'd1 : ecnt_q;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      pos_q   <= '0;
      crc_q   <= CRC_INIT;
      lt_q    <= '0;
      pre_q   <= 1'b0;
      hdr_q   <= 1'b0;
      code_q  <= 1'b0;
      size_q  <= 1'b0;
      done_q  <= 1'b0;
      flags_q <= '0;
      fcnt_q  <= '0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      crc_q   <= crc_d;
      lt_q    <= lt_d;
      pre_q   <= pre_d;
      hdr_q   <= hdr_d;
      code_q  <= code_d;
      size_q  <= size_d;
      done_q  <= done_d;
      flags_q <= flags_d;
      fcnt_q  <= fcnt_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign o_frame_done     = done_q;
  assign o_preamble_error = flags_q.preamble;
  assign o_header_error   = flags_q.header;
  assign o_payload_error  = flags_q.payload;
  assign o_fcs_error      = flags_q.fcs;
  assign o_size_error     = flags_q.size;
  assign o_code_error     = flags_q.code;
  assign o_frame_count    = fcnt_q;
  assign o_error_count    = ecnt_q;

endmodule

// File: tb/tb_mac_stream_checker.sv
// Directed bench for mac_stream_checker: 64-bit and 128-bit instances driven from
// byte-level frame images with bench-computed FCS.
module tb_mac_stream_checker;

  localparam logic [47:0] DA = 48'hFFFFFFFFFFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [63:0]  d64;  logic [7:0]  c64;  logic v64;
  logic [127:0] d128; logic [15:0] c128; logic v128;
  logic done64, done128;
  logic [5:0] fl64, fl128;
  logic [31:0] fc64, ec64, fc128, ec128;

  mac_stream_checker #(.DATA_WIDTH(64), .CTRL_WIDTH(8)) dut64 (
    .clk(clk), .i_rst_n(rst_n), .i_rx_data(d64), .i_rx_ctrl(c64), .i_data_valid(v64),
    .o_frame_done(done64), .o_preamble_error(fl64[5]), .o_header_error(fl64[4]),
    .o_payload_error(fl64[3]), .o_fcs_error(fl64[2]), .o_size_error(fl64[1]),
    .o_code_error(fl64[0]), .o_frame_count(fc64), .o_error_count(ec64));

  mac_stream_checker #(.DATA_WIDTH(128), .CTRL_WIDTH(16)) dut128 (
    .clk(clk), .i_rst_n(rst_n), .i_rx_data(d128), .i_rx_ctrl(c128), .i_data_valid(v128),
    .o_frame_done(done128), .o_preamble_error(fl128[5]), .o_header_error(fl128[4]),
    .o_payload_error(fl128[3]), .o_fcs_error(fl128[2]), .o_size_error(fl128[1]),
    .o_code_error(fl128[0]), .o_frame_count(fc128), .o_error_count(ec128));

  int checks = 0, failures = 0;
  logic [7:0] bq[$];
  bit         cq[$];
  logic [5:0] mon_q[$];

  always @(negedge clk) if (done64) mon_q.push_back(fl64);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] bt);
    logic [31:0] r;
    r = c ^ {24'h0, bt};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic push(input logic [7:0] bt, input bit ct);
    bq.push_back(bt);
    cq.push_back(ct);
  endtask

  // Frame image: START, preamble (byte 3 selectable), SFD, DA, SA, LT, payload, FCS, TERM.
  task automatic build(input logic [47:0] da, input logic [7:0] pre3, input logic [15:0] lt,
                       input int pay, input logic [7:0] fx);
    logic [31:0] crc;
    logic [47:0] sa;
    logic [7:0]  bt;
    sa = 48'h123456789ABC;
    bq.delete(); cq.delete();
    push(8'hFB, 1'b1);
    for (int i = 1; i <= 6; i++) push((i == 3) ? pre3 : 8'h55, 1'b0);
    push(8'hD5, 1'b0);
    crc = 32'hFFFFFFFF;
    for (int i = 0; i < 6; i++) begin bt = da[47-8*i -: 8]; push(bt, 1'b0); crc = crc_byte(crc, bt); end
    for (int i = 0; i < 6; i++) begin bt = sa[47-8*i -: 8]; push(bt, 1'b0); crc = crc_byte(crc, bt); end
    bt = lt[15:8]; push(bt, 1'b0); crc = crc_byte(crc, bt);
    bt = lt[7:0];  push(bt, 1'b0); crc = crc_byte(crc, bt);
    for (int i = 0; i < pay; i++) begin bt = 8'(i * 7 + 3); push(bt, 1'b0); crc = crc_byte(crc, bt); end
    crc = ~crc;
    for (int i = 0; i < 4; i++) begin
      bt = crc[8*i +: 8];
      if (i == 3) bt = bt ^ fx;
      push(bt, 1'b0);
    end
    push(8'hFD, 1'b1);
  endtask

  task automatic drive(input bit w128, input bit v, input logic [127:0] d, input logic [15:0] c);
    if (w128) begin v128 = v; d128 = d; c128 = c; end
    else begin v64 = v; d64 = d[63:0]; c64 = c[7:0]; end
  endtask

  // Sends up to maxw words (all if negative); idle-pads the last word after TERM.
  task automatic send(input bit w128, input bit gaps, input int maxw);
    int lanes;
    int nw;
    lanes = w128 ? 16 : 8;
    nw = 0;
    while (bq.size() > 0 && (maxw < 0 || nw < maxw)) begin
      logic [127:0] d;
      logic [15:0]  c;
      if (gaps && (nw % 3 == 2)) begin
        drive(w128, 1'b0, {16{8'hFB}}, 16'hFFFF);
        @(posedge clk); #1;
      end
      d = '0; c = '0;
      for (int l = 0; l < lanes; l++) begin
        if (bq.size() > 0) begin d[8*l +: 8] = bq.pop_front(); c[l] = cq.pop_front(); end
        else begin d[8*l +: 8] = 8'h07; c[l] = 1'b1; end
      end
      drive(w128, 1'b1, d, c);
      @(posedge clk); #1;
      nw++;
    end
    drive(w128, 1'b0, '0, '0);
  endtask

  typedef struct {
    bit          w128;
    logic [47:0] da;
    logic [7:0]  pre3;
    logic [15:0] lt;
    int          pay;
    logic [7:0]  fx;
    bit          gaps;
    logic [5:0]  ef;   // {pre, hdr, payload, fcs, size, code}
    int          efc;
    int          eec;
  } vec_t;

  vec_t tv[11];

  initial begin
    logic       adone;
    logic [5:0] af;
    logic [31:0] afc, aec;

    tv[0]  = '{1'b0, DA,     8'h55, 16'h002E,   46, 8'h00, 1'b0, 6'b000000, 1, 0};
    tv[1]  = '{1'b0, DA,     8'h55, 16'h002E,   46, 8'h01, 1'b0, 6'b000100, 2, 1};
    tv[2]  = '{1'b0, DA,     8'h55, 16'h0040,   60, 8'h00, 1'b0, 6'b001000, 3, 2};
    tv[3]  = '{1'b0, 48'h0,  8'h54, 16'h002E,   46, 8'h00, 1'b0, 6'b110000, 4, 3};
    tv[4]  = '{1'b0, DA,     8'h55, 16'h0800,  100, 8'h00, 1'b1, 6'b000000, 5, 3};
    tv[5]  = '{1'b0, DA,     8'h55, 16'h0014,   20, 8'h00, 1'b0, 6'b001010, 6, 4};
    tv[6]  = '{1'b0, DA,     8'h55, 16'h05DD,   46, 8'h00, 1'b0, 6'b001000, 7, 5};
    tv[7]  = '{1'b1, DA,     8'h55, 16'h0800, 1582, 8'h00, 1'b0, 6'b000010, 1, 1};
    tv[8]  = '{1'b1, DA,     8'h55, 16'h0033,   51, 8'h00, 1'b0, 6'b000000, 2, 1};
    tv[9]  = '{1'b0, DA,     8'h55, 16'h05DC, 1500, 8'h00, 1'b1, 6'b000000, 8, 5};
    tv[10] = '{1'b0, DA,     8'h55, 16'h0800, 1501, 8'h00, 1'b0, 6'b000010, 9, 6};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_done64", {31'b0, done64}, 0);
    chk("reset_flags64", {26'b0, fl64}, 0);
    chk("reset_fcnt64", fc64, 0);
    chk("reset_ecnt64", ec64, 0);
    chk("reset_flags128", {26'b0, fl128}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      build(tv[i].da, tv[i].pre3, tv[i].lt, tv[i].pay, tv[i].fx);
      send(tv[i].w128, tv[i].gaps, -1);
      adone = tv[i].w128 ? done128 : done64;
      af    = tv[i].w128 ? fl128   : fl64;
      afc   = tv[i].w128 ? fc128   : fc64;
      aec   = tv[i].w128 ? ec128   : ec64;
      chk($sformatf("v%0d_done", i), {31'b0, adone}, 1);
      chk($sformatf("v%0d_flags", i), {26'b0, af}, {26'b0, tv[i].ef});
      chk($sformatf("v%0d_fcnt", i), afc, tv[i].efc);
      chk($sformatf("v%0d_ecnt", i), aec, tv[i].eec);
      @(posedge clk); #1;
      adone = tv[i].w128 ? done128 : done64;
      af    = tv[i].w128 ? fl128   : fl64;
      chk($sformatf("v%0d_done_drop", i), {31'b0, adone}, 0);
      chk($sformatf("v%0d_flags_clear", i), {26'b0, af}, 0);
    end

    // TERM inside the preamble
    bq.delete(); cq.delete();
    push(8'hFB, 1'b1);
    for (int i = 0; i < 4; i++) push(8'h55, 1'b0);
    push(8'hFD, 1'b1);
    send(1'b0, 1'b0, -1);
    chk("short_term_done", {31'b0, done64}, 1);
    chk("short_term_flags", {26'b0, fl64}, 32'h22);
    @(posedge clk); #1;

    // START in lane 0 mid-frame aborts the old frame and starts a new one
    mon_q.delete();
    build(DA, 8'h55, 16'h002E, 46, 8'h00);
    send(1'b0, 1'b0, 3);
    build(DA, 8'h55, 16'h002E, 46, 8'h00);
    send(1'b0, 1'b0, -1);
    repeat (2) @(posedge clk);
    #1;
    chk("restart_reports", mon_q.size(), 2);
    chk("restart_first", {26'b0, (mon_q.size() > 0) ? mon_q[0] : 6'h3F}, 32'h01);
    chk("restart_second", {26'b0, (mon_q.size() > 1) ? mon_q[1] : 6'h3F}, 32'h00);

    // Stray control byte inside the payload
    build(DA, 8'h55, 16'h002E, 46, 8'h00);
    bq[30] = 8'h07;
    cq[30] = 1'b1;
    send(1'b0, 1'b0, -1);
    chk("code_err_done", {31'b0, done64}, 1);
    chk("code_err_flag", {31'b0, fl64[0]}, 1);
    chk("totals_fcnt64", fc64, 13);
    chk("totals_ecnt64", ec64, 9);
    @(posedge clk); #1;

    // Reset in the middle of a payload
    build(DA, 8'h55, 16'h002E, 46, 8'h00);
    send(1'b0, 1'b0, 5);
    rst_n = 1'b0;
    #2;
    chk("midreset_fcnt64", fc64, 0);
    chk("midreset_ecnt64", ec64, 0);
    chk("midreset_fcnt128", fc128, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_q.delete();
    @(posedge clk); #1;
    build(DA, 8'h55, 16'h002E, 46, 8'h00);
    send(1'b0, 1'b0, -1);
    repeat (3) @(posedge clk);
    #1;
    chk("postreset_reports", mon_q.size(), 1);
    chk("postreset_flags", {26'b0, (mon_q.size() > 0) ? mon_q[0] : 6'h3F}, 0);
    chk("postreset_fcnt64", fc64, 1);
    chk("postreset_ecnt64", ec64, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mac_stream_checker.md
MAC_STREAM_CHECKER -- requirements
Module: mac_stream_checker

Interface
REQ-001 Parameter DATA_WIDTH, default 64, receive data bus width in bits; legal values are 64 and 128.
REQ-002 Parameter CTRL_WIDTH, default 8, number of lanes; it SHALL equal DATA_WIDTH/8, with one control bit per byte lane.
REQ-003 Parameters IDLE_CODE 8'h07, START_CODE 8'hFB, TERM_CODE 8'hFD, PREAMBLE_CODE 8'h55 and SFD_CODE 8'hD5 SHALL be the line codes.
REQ-004 Parameters DST_ADDR_CODE 48'hFFFFFFFFFFFF and SRC_ADDR_CODE 48'h123456789ABC SHALL be the expected addresses, and CHECK_ADDR, default 1, SHALL enable address comparison.
REQ-005 Parameters MIN_FRAME_SIZE 64 and MAX_FRAME_SIZE 1518 SHALL be byte limits, counted from DA to FCS inclusive.
REQ-006 Ports: clk  in  1  clock; i_rst_n  in  1  async active-low reset.
REQ-007 Ports: i_rx_data  in  DATA_WIDTH  data; byte lane n is bits [8n+7:8n], and lane 0 is first on the wire.
REQ-008 Ports: i_rx_ctrl  in  CTRL_WIDTH  per-lane control flag; i_data_valid  in  1  word qualifier.
REQ-009 Ports: o_frame_done  out  1  single-cycle result strobe.
REQ-010 Ports: o_preamble_error, o_header_error, o_payload_error, o_fcs_error, o_size_error, o_code_error  out  1 each  error flags, valid while o_frame_done is high.
REQ-011 Ports: o_frame_count and o_error_count  out  32 each  saturating statistics.

Function
REQ-012 Words with i_data_valid low SHALL be ignored, and all state SHALL hold.
REQ-013 The FSM SHALL have three states: IDLE, FRAME and DROP. In IDLE it SHALL go to FRAME on START_CODE with ctrl=1 in lane 0. A START_CODE in any other lane SHALL be ignored.
REQ-014 An 11-bit byte-position counter SHALL be set to 0 at START and SHALL advance by CTRL_WIDTH per valid word, saturating at 2047.
REQ-015 Positions 1-6 SHALL equal PREAMBLE_CODE and position 7 SHALL equal SFD_CODE, all with ctrl=0; any mismatch SHALL set the sticky preamble error.
REQ-016 When CHECK_ADDR=1, positions 8-13 (DA) and 14-19 (SA) SHALL be compared with the parameters, and any mismatch SHALL set the sticky header error. Positions 20-21 SHALL be captured as the big-endian length/type field (LT).
REQ-017 CRC-32 SHALL be computed over every byte from position 8 up to the byte before TERM. It SHALL use the reflected polynomial 32'hEDB88320, init 32'hFFFFFFFF, all CTRL_WIDTH lanes per cycle, and no final inversion.
REQ-018 At TERM, the fcs error SHALL be set if the CRC register is not 32'hDEBB20E3.
REQ-019 TERM is ctrl=1 with TERM_CODE in any lane at position p, and p SHALL end the frame. Frame size is p-8, payload count is p-26, and lanes after TERM in the same word SHALL be ignored.
REQ-020 The size error SHALL be set if frame size < MIN_FRAME_SIZE or > MAX_FRAME_SIZE.
REQ-021 Payload check when LT <= 1500: LT >= 46 requires payload count == LT, and LT < 46 requires payload count == 46.
REQ-022 LT in 1501-1535 SHALL set the payload error; LT >= 1536 is a type and SHALL NOT be checked.
REQ-023 A ctrl=1 byte at position >= 1 that is not TERM_CODE SHALL set the code error and move the FSM to DROP.
REQ-024 DROP SHALL wait for TERM and then report the frame.
REQ-025 When the counter saturates without TERM, the FSM SHALL set the size error and move to DROP.
REQ-026 START in lane 0 while in FRAME or DROP SHALL report the current frame with code error, in the same cycle as the REQ-027 strobe, and SHALL begin a new frame from that word.
REQ-027 Latency: o_frame_done and the registered flags SHALL assert one clk after the valid word containing TERM, for exactly one cycle.
REQ-028 Outside the o_frame_done cycle, every flag SHALL be 0.
REQ-029 o_frame_count SHALL increment on each o_frame_done.
REQ-030 o_error_count SHALL increment when any flag is set; both counters SHALL saturate at 32'hFFFFFFFF.
REQ-031 A TERM at position < 8 SHALL be reported with preamble and size errors.

Reset
REQ-032 Asserting i_rst_n low SHALL asynchronously force IDLE, clear the position counter and sticky errors, set the CRC to 32'hFFFFFFFF, and zero all outputs and counters.
REQ-033 A reset mid-frame SHALL discard the frame without an o_frame_done pulse; checking SHALL resume at the next START after deassertion.

Structure
REQ-034 Package mac_pkg SHALL hold the line codes, the frame size limits, the CRC polynomial and residue constants, and the FSM state enum.
REQ-035 Sub-module crc32_lanes SHALL be a combinational N-byte reflected CRC update with a per-lane enable mask; the checker SHALL register its result.

Verification
REQ-036 64-bit: FB+55x6+D5, DA/SA default, LT 16'h002E, 46 payload bytes, correct FCS, FD -> done one clk after FD; all flags 0; frame_count=1.
REQ-037 Same frame with the last FCS byte XOR 8'h01 -> fcs error only; error_count=1.
REQ-038 LT 16'h0040 with 60 payload bytes and valid FCS -> payload error only.
REQ-039 Preamble byte 3 = 8'h54 and DA = 48'h0 with CHECK_ADDR=1 -> preamble and header errors.
REQ-040 DATA_WIDTH=128: 1600-byte frame -> size error; next a legal frame with TERM in lane 13 -> clean result; counters 2/1.
REQ-041 Reset pulse mid-payload, then a legal frame -> exactly one done; frame_count=1.
